// File: rtl/cpu_mem_sequencer_if.sv
// Shared single-port memory bus between the sequencer (master) and memory (slave).
// Requests are held until a one-cycle ack; ack may come in the same cycle as req.
interface cpu_mem_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/cpu_mem_sequencer.sv
// Serializes one data access and one instruction fetch per CPU step onto a single
// memory port, stalling the core via NOP, with a watchdog that aborts unacked accesses.
module cpu_mem_sequencer #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    input  logic        I_Read,
    output logic [31:0] ins,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_WriteData,
    input  logic [3:0]  D_Write,
    input  logic        D_Read,
    output logic [31:0] D_ReadData,
    output logic        NOP,
    output logic        bus_err,
    cpu_mem_sequencer_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ins_q, ins_d;
    logic [31:0]        drd_q, drd_d;
    logic               err_q, err_d;

    logic               req;
    logic [31:0]        addr;
    logic [3:0]         we;
    logic [31:0]        wdata;
    logic               has_data;
    logic               is_store;
    logic               expired;
    logic               acc_end;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ins_d    = ins_q;
        drd_d    = drd_q;
        err_d    = err_q;
        req      = 1'b0;
        addr     = '0;
        we       = '0;
        wdata    = '0;
        has_data = D_Read || (D_Write != 4'b0000);
        is_store = (D_Write != 4'b0000);
        // An ack in the final watchdog cycle takes priority over the abort.
        expired  = (cnt_q == CNT_W'(TIMEOUT - 1)) && !mem.mem_ack;
        acc_end  = mem.mem_ack || expired;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (has_data) begin
                    state_d = DREQ;
                end else if (I_Read) begin
                    state_d = IREQ;
                end else begin
                    state_d = DONE;
                end
            end

            DREQ: begin
                req   = 1'b1;
                addr  = D_Addr;
                we    = D_Write;
                wdata = D_WriteData;
                if (mem.mem_ack) begin
                    if (!is_store) begin
                        drd_d = mem.mem_rdata;
                    end
                end else if (expired) begin
                    err_d = 1'b1;
                    if (!is_store) begin
                        drd_d = '0;
                    end
                end
                if (acc_end) begin
                    cnt_d   = '0;
                    state_d = I_Read ? IREQ : DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            IREQ: begin
                req  = 1'b1;
                addr = pc;
                if (mem.mem_ack) begin
                    ins_d = mem.mem_rdata;
                end else if (expired) begin
                    err_d = 1'b1;
                    ins_d = NOP_INSN;
                end
                if (acc_end) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ins_q   <= NOP_INSN;
            drd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            drd_q   <= drd_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode from the registered state so reset drops mem_req at once.
    assign mem.mem_req   = req;
    assign mem.mem_addr  = addr;
    assign mem.mem_we    = we;
    assign mem.mem_wdata = wdata;

    assign NOP        = (state_q != DONE);
    assign ins        = ins_q;
    assign D_ReadData = drd_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Self-checking bench for cpu_mem_sequencer: directed steps plus randomized steps,
// each checked against a per-step access-sequence model and a reference memory.
module tb_cpu_mem_sequencer;

    localparam int unsigned TO       = 4;
    localparam int unsigned NEVER    = 1000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic        clk;
    logic        resetn;
    logic [31:0] pc;
    logic        I_Read;
    logic [31:0] ins;
    logic [31:0] D_Addr;
    logic [31:0] D_WriteData;
    logic [3:0]  D_Write;
    logic        D_Read;
    logic [31:0] D_ReadData;
    logic        NOP;
    logic        bus_err;

    cpu_mem_sequencer_if bus ();

    cpu_mem_sequencer #(
        .TIMEOUT  (TO),
        .CNT_W    (8),
        .NOP_INSN (NOP_INSN)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pc          (pc),
        .I_Read      (I_Read),
        .ins         (ins),
        .D_Addr      (D_Addr),
        .D_WriteData (D_WriteData),
        .D_Write     (D_Write),
        .D_Read      (D_Read),
        .D_ReadData  (D_ReadData),
        .NOP         (NOP),
        .bus_err     (bus_err),
        .mem         (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Memory side: word array, ack after ack_delay wait cycles, optional stray ack.
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    int unsigned ack_delay;
    int unsigned req_cnt;
    logic        stray_ack;

    assign bus.mem_ack   = stray_ack || (bus.mem_req && (req_cnt == ack_delay));
    assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_cnt <= 0;
        end else if (!bus.mem_req || bus.mem_ack) begin
            req_cnt <= 0;
        end else begin
            req_cnt <= req_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) begin
                    mem_arr[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "global timeout");
    end

    // Reference state
    logic [31:0] exp_ins;
    logic [31:0] exp_drd;
    logic        exp_err;

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem_arr[a[9:2]] <= v;
        ref_mem[a[9:2]] = v;
    endtask

    task automatic run_step(input logic dr, input logic [3:0] dw, input logic [31:0] da,
                            input logic [31:0] dwd, input logic ir, input logic [31:0] p,
                            input int unsigned dly, input string name);
        logic        e_req [32];
        logic [31:0] e_addr [32];
        logic [3:0]  e_we [32];
        logic [31:0] e_wd [32];
        logic        e_chk [32];
        logic        g_req [64];
        logic [31:0] g_addr [64];
        logic [3:0]  g_we [64];
        logic [31:0] g_wd [64];
        int          n;
        int          got;
        int          lim;
        int          nreq;
        logic        td;
        logic [31:0] w;

        td   = (dly >= TO);
        nreq = td ? int'(TO) : int'(dly) + 1;
        n    = 0;
        e_req[n] = 1'b0; e_addr[n] = '0; e_we[n] = '0; e_wd[n] = '0; e_chk[n] = 1'b1; n++;
        if (dr || dw != 4'b0000) begin
            for (int k = 0; k < nreq; k++) begin
                e_req[n] = 1'b1; e_addr[n] = da; e_we[n] = dw; e_wd[n] = dwd; e_chk[n] = 1'b1; n++;
            end
            if (td) exp_err = 1'b1;
            if (dw != 4'b0000) begin
                if (!td) begin
                    w = ref_mem[da[9:2]];
                    for (int b = 0; b < 4; b++) if (dw[b]) w[8*b +: 8] = dwd[8*b +: 8];
                    ref_mem[da[9:2]] = w;
                end
            end else begin
                exp_drd = td ? 32'h0 : ref_mem[da[9:2]];
            end
        end
        if (ir) begin
            for (int k = 0; k < nreq; k++) begin
                e_req[n] = 1'b1; e_addr[n] = p; e_we[n] = '0; e_wd[n] = '0; e_chk[n] = 1'b0; n++;
            end
            if (td) exp_err = 1'b1;
            exp_ins = td ? NOP_INSN : ref_mem[p[9:2]];
        end
        e_req[n] = 1'b0; e_addr[n] = '0; e_we[n] = '0; e_wd[n] = '0; e_chk[n] = 1'b1; n++;

        D_Read = dr; D_Write = dw; D_Addr = da; D_WriteData = dwd;
        I_Read = ir; pc = p; ack_delay = dly;

        got = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            g_req[c] = bus.mem_req; g_addr[c] = bus.mem_addr;
            g_we[c] = bus.mem_we; g_wd[c] = bus.mem_wdata;
            got = c + 1;
            if (!NOP) break;
        end

        checks++;
        if (got !== n) begin
            failures++;
            $display("FAIL %s step_cycles: got %0d required %0d", name, got, n);
        end
        lim = (got < n) ? got : n;
        for (int c = 0; c < lim; c++) begin
            checks++;
            if (g_req[c] !== e_req[c] || g_addr[c] !== e_addr[c] || g_we[c] !== e_we[c] ||
                (e_chk[c] && g_wd[c] !== e_wd[c])) begin
                failures++;
                $display("FAIL %s bus_cycle%0d: got req=%b addr=%h we=%b wd=%h required req=%b addr=%h we=%b wd=%h",
                         name, c, g_req[c], g_addr[c], g_we[c], g_wd[c],
                         e_req[c], e_addr[c], e_we[c], e_wd[c]);
            end
        end
        checks++;
        if (ins !== exp_ins || D_ReadData !== exp_drd || bus_err !== exp_err) begin
            failures++;
            $display("FAIL %s results: got ins=%h drd=%h err=%b required ins=%h drd=%h err=%b",
                     name, ins, D_ReadData, bus_err, exp_ins, exp_drd, exp_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (NOP !== 1'b1 || ins !== exp_ins || D_ReadData !== exp_drd) begin
            failures++;
            $display("FAIL %s hold_after_done: got nop=%b ins=%h drd=%h required nop=1 ins=%h drd=%h",
                     name, NOP, ins, D_ReadData, exp_ins, exp_drd);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; stray_ack = 1'b0; ack_delay = 0;
        pc = '0; I_Read = 1'b0; D_Addr = '0; D_WriteData = '0; D_Write = '0; D_Read = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] <= (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (NOP !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_we !== 4'h0 || bus.mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got nop=%b req=%b addr=%h we=%b wd=%h required nop=1 req=0 addr=0 we=0 wd=0",
                     NOP, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        checks++;
        if (ins !== NOP_INSN || D_ReadData !== 32'h0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got ins=%h drd=%h err=%b required ins=%h drd=0 err=0",
                     ins, D_ReadData, bus_err, NOP_INSN);
        end
        exp_ins = NOP_INSN; exp_drd = '0; exp_err = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_fetch();
        set_word(32'h0, 32'h0050_0093);
        for (int k = 0; k < 3; k++) run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'h0, 0, "fetch");
    endtask

    task automatic test_load_fetch();
        set_word(32'h100, 32'hDEAD_BEEF);
        run_step(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 32'h4, 0, "load_fetch");
    endtask

    task automatic test_store();
        run_step(1'b0, 4'b0011, 32'h200, 32'h0000_ABCD, 1'b0, 32'h4, 3, "store_delayed");
        run_step(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 32'h4, 1, "store_readback");
    endtask

    task automatic test_timeout_boundary();
        set_word(32'h8, 32'h1234_5678);
        run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'h8, TO - 1, "ack_at_timeout");
    endtask

    task automatic test_timeout();
        run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'hC, NEVER, "fetch_timeout");
        run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'h10, 0, "after_timeout");
        run_step(1'b1, 4'h0, 32'h100, '0, 1'b1, 32'h14, NEVER, "load_fetch_timeout");
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        dr;
        logic [3:0]  dw;
        logic        ir;
        logic [31:0] da;
        logic [31:0] p;
        int unsigned d;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom();
            dr = r[0];
            dw = (r[3:2] == 2'b00) ? r[7:4] : 4'h0;
            ir = r[8];
            da = {22'h0, r[15:8], 2'b00};
            p  = {22'h0, r[23:16], 2'b00};
            d  = $urandom_range(0, 7);
            if (d >= 6) d = NEVER; else d = d % 4;
            run_step(dr, dw, da, $urandom(), ir, p, d, "random");
        end
    endtask

    task automatic test_async_reset();
        int guard;
        set_word(32'h40, 32'hCAFE_F00D);
        D_Read = 1'b1; D_Write = 4'h0; D_Addr = 32'h40; I_Read = 1'b0; ack_delay = NEVER;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got req=%b required req=1", bus.mem_req);
        end
        #3 resetn = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || NOP !== 1'b1 || D_ReadData !== 32'h0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: got req=%b nop=%b drd=%h err=%b required req=0 nop=1 drd=0 err=0",
                     bus.mem_req, NOP, D_ReadData, bus_err);
        end
        D_Read = 1'b0; ack_delay = 0; stray_ack = 1'b1;
        exp_ins = NOP_INSN; exp_drd = '0; exp_err = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (D_ReadData !== 32'h0 || ins !== NOP_INSN || bus_err !== 1'b0) begin
                failures++;
                $display("FAIL stray_ack_cycle%0d: got drd=%h ins=%h err=%b required drd=0 ins=%h err=0",
                         c, D_ReadData, ins, bus_err, NOP_INSN);
            end
        end
        stray_ack = 1'b0;
        guard = 0;
        while (NOP !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            failures++;
            $display("FAIL resync_done: got no DONE within 20 cycles required DONE");
        end
        @(posedge clk);
        #1;
        run_step(1'b1, 4'h0, 32'h40, '0, 1'b1, 32'h0, 0, "after_areset");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_fetch();
        test_store();
        test_timeout_boundary();
        test_timeout();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_sequencer.md
Name: cpu_mem_sequencer

Overview:
- Sits between the five-stage CPU core and a single-port memory; the core's instruction port and data port share that one memory port.
- Per CPU step, the block serializes at most one data access and one instruction fetch onto the shared port, stalling the core through its NOP input while accesses are in flight.
- It releases the core for exactly one clock with stable fetch and load results.
- A watchdog aborts accesses the memory never acknowledges and flags a sticky bus error.

Parameters:
- TIMEOUT, 255: max cycles a request waits for ack before abort; must be >= 1.
- CNT_W, 8: watchdog counter width; 2**CNT_W > TIMEOUT.
- NOP_INSN, 32'h0000_0013: instruction returned on aborted fetch and held in ins at reset.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pc  in  32  fetch address from core.
- I_Read  in  1  core requests fetch this step.
- ins  out  32  fetched instruction to core, registered.
- D_Addr  in  32  data address from core MEM stage.
- D_WriteData  in  32  store data, already lane-aligned.
- D_Write  in  4  byte write enables; nonzero means store.
- D_Read  in  1  load request.
- D_ReadData  out  32  load data to core, registered.
- NOP  out  1  stall to core; 1 = hold pipeline.
- mem_req  out  1  access request, held until ack.
- mem_addr  out  32  access address.
- mem_we  out  4  byte write enables; 0 = read.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion; may assert in same cycle as mem_req.
- bus_err  out  1  sticky: some access timed out.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, NOP=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ins=NOP_INSN, D_ReadData=0, bus_err=0, watchdog=0.
  - mem_req drops immediately even mid-access; an in-flight ack after release is ignored.
- Core inputs are stable whenever NOP=1; the block samples them in IDLE and during requests without extra latching.
- FSM states: IDLE, DREQ, IREQ, DONE. NOP=0 only in DONE.
- IDLE:
  - If D_Read or D_Write!=0, go to DREQ.
  - Else if I_Read, go to IREQ.
  - Else go to DONE.
  - D_Read and D_Write!=0 together is treated as a store; the load is not performed and D_ReadData is unchanged.
- DREQ:
  - Outputs: mem_req=1, mem_addr=D_Addr, mem_we=D_Write (0 for loads), mem_wdata=D_WriteData.
  - On mem_ack: if load, D_ReadData<=mem_rdata.
  - Then go to IREQ if I_Read, else DONE.
- IREQ:
  - Outputs: mem_req=1, mem_addr=pc, mem_we=0.
  - On mem_ack: ins<=mem_rdata, go to DONE.
- DONE:
  - NOP=0 for exactly one cycle; core advances on this edge.
  - Go to IDLE.
  - ins and D_ReadData hold their values through DONE and until the next capture.
- mem_addr, mem_we, mem_wdata are 0 whenever mem_req=0.
- Latency with same-cycle ack:
  - Fetch only: 3 clocks per step (IDLE, IREQ, DONE).
  - Load/store plus fetch: 4 clocks per step.
  - Each wait cycle adds 1.
- Watchdog:
  - Clears on entry to DREQ/IREQ; increments each cycle in DREQ/IREQ without ack.
  - When count==TIMEOUT-1 and no ack, the access aborts:
    - Load: D_ReadData<=0.
    - Fetch: ins<=NOP_INSN.
    - Store: dropped.
  - On abort: bus_err<=1, mem_req deasserts next cycle, FSM proceeds as if acked.
  - An ack arriving in the same cycle as the timeout wins: normal capture, no error.
- mem_ack outside DREQ/IREQ is ignored and has no side effects.
- bus_err clears only on reset.

Test Plan:
- Reset, hold resetn=0, then release; memory acks same cycle, pc=0x0, mem_rdata=0x00500093 -> NOP=1 out of reset; mem_req with mem_addr=0 in IREQ; NOP=0 two clocks after IDLE entry; ins=0x00500093; 3-clock period repeats.
- Load: D_Read=1, D_Addr=0x100, mem_rdata=0xDEADBEEF on data ack, then fetch pc=0x4 -> DREQ addr 0x100, we=0; then IREQ addr 0x4; D_ReadData=0xDEADBEEF; NOP low exactly 1 cycle out of 4.
- Store: D_Write=4'b0011, D_Addr=0x200, D_WriteData=0x0000ABCD, ack delayed 3 cycles -> mem_we=0011 and wdata held all 4 request cycles; D_ReadData unchanged; NOP=1 throughout.
- Timeout with TIMEOUT=4, fetch never acked -> mem_req high 4 cycles, ins=0x00000013, bus_err=1 and stays set; the following step fetches normally.
- Timeout boundary: ack on the 4th request cycle with TIMEOUT=4, rdata=0x12345678 -> ins=0x12345678, bus_err stays 0.
- Async reset asserted mid-DREQ with mem_req=1 -> mem_req=0 and NOP=1 immediately; a late ack after release does not change D_ReadData (stays 0).
